// File: rtl/mmio_uart_tx_if.sv
// Memory-mapped bus between the CPU data-memory port and mmio_uart_tx.
// Handshake: this bus has no valid/ready pair. The slave is always ready, so
// every rising edge is one access. A store takes effect on that edge when
// web[0]=1. A read returns rdata on the following edge.
interface mmio_uart_tx_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            web;
  logic [31:0]           wdata;
  logic [31:0]           rdata;

  modport master (output addr, output web, output wdata, input rdata);
  modport slave  (input addr, input web, input wdata, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter.
// A store to TX_ADDR queues one byte in a small FIFO. A serialiser drains the
// FIFO onto tx as 8N1 frames. A load from STAT_ADDR returns
// {overflow, empty, full, busy}.
// Optional feature macro UART_TX_PARITY_EN: adds an even-parity bit (8E1) and
// sets STAT bit 4 to advertise the feature.
module mmio_uart_tx #(
  parameter int                    ADDR_WIDTH   = 13,
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR      = 13'h1FF0,
  parameter logic [ADDR_WIDTH-1:0] STAT_ADDR    = 13'h1FF1,
  parameter int                    FIFO_DEPTH   = 8,
  parameter int                    CLKS_PER_BIT = 868
) (
  input  logic                sysclk,
  input  logic                rst,
  mmio_uart_tx_if.slave       bus,
  output logic                tx,
  output logic                busy,
  output logic [2:0]          dbg_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
  localparam logic FEAT_PARITY = 1'b1;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
  localparam logic FEAT_PARITY = 1'b0;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   rdata_q;

  // Serialiser state
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic push_req, push_ok, pop, full, empty, ovf_set, ovf_clr, busy_w;
  logic unused_bus_bits;

  assign unused_bus_bits = ^{bus.web[3:1], bus.wdata[31:8]};

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = (bus.addr == TX_ADDR) && bus.web[0];
  // The FSM pops when idle, or at the end of a stop bit for back-to-back frames.
  assign pop      = !empty && ((state_q == S_IDLE) ||
                               ((state_q == S_STOP) && (baud_q == '0)));
  // When full, a same-cycle pop frees the slot, so the push is still accepted.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = (bus.addr == STAT_ADDR) && bus.web[0] && bus.wdata[3];
  assign busy_w   = !empty || (state_q != S_IDLE);

  // Next FIFO occupancy and sticky overflow (a set in the same cycle beats a clear)
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (ovf_set)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // FIFO data array (contents need no reset; the pointers define validity)
  always_ff @(posedge sysclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.wdata[7:0];
  end

  // FIFO pointers, count, overflow flag and registered status read port
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (bus.addr == STAT_ADDR)
        rdata_q <= {27'b0, FEAT_PARITY, overflow_q, empty, full, busy_w};
      else
        rdata_q <= '0;
    end
  end

  // Frame FSM. tx_q follows the state one cycle later, so the line comes
  // straight from a flop.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shreg_q <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_q   <= ^mem_q[rd_ptr_q];
`endif
            baud_q  <= BAUD_MAX;
            state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (baud_q == '0) begin
            baud_q    <= BAUD_MAX;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_DATA: begin
          tx_q <= shreg_q[0];
          if (baud_q == '0) begin
            baud_q  <= BAUD_MAX;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx_q <= par_q;
          if (baud_q == '0) begin
            baud_q  <= BAUD_MAX;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_q == '0) begin
            if (pop) begin
              shreg_q <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
              par_q   <= ^mem_q[rd_ptr_q];
`endif
              baud_q  <= BAUD_MAX;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_w;
  assign bus.rdata   = rdata_q;
  assign dbg_state_o = state_q;

endmodule
